// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared RV32I decode constants, record type and decode helper
// Purpose: opcode constants, instruction-format codes, access-size codes and the
//          combinational decode function used by decode_stage.
// Ports:   none (package).
package decode_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ITYPE_R    = 3'd0,
    ITYPE_I    = 3'd1,
    ITYPE_S    = 3'd2,
    ITYPE_B    = 3'd3,
    ITYPE_U    = 3'd4,
    ITYPE_J    = 3'd5,
    ITYPE_NONE = 3'd7
  } itype_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Immediate is kept at 32 bits here; the stage sign-extends it to XLEN.
  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    itype_e      itype;
    logic [1:0]  size;
    logic        is_unsigned;
  } dec_t;

  // Fields not carried by the instruction's format stay zero.
  function automatic dec_t decode(input logic [31:0] instr);
    dec_t d;
    d       = '0;
    d.itype = ITYPE_NONE;
    d.size  = SIZE_WORD;
    case (instr[6:0])
      OPC_OP: begin
        d.itype = ITYPE_R;
        d.rd    = instr[11:7];
        d.func3 = instr[14:12];
        d.rs1   = instr[19:15];
        d.rs2   = instr[24:20];
        d.func7 = instr[31:25];
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        d.itype = ITYPE_I;
        d.rd    = instr[11:7];
        d.func3 = instr[14:12];
        d.rs1   = instr[19:15];
        d.imm   = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        d.itype = ITYPE_S;
        d.func3 = instr[14:12];
        d.rs1   = instr[19:15];
        d.rs2   = instr[24:20];
        d.imm   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        d.itype = ITYPE_B;
        d.func3 = instr[14:12];
        d.rs1   = instr[19:15];
        d.rs2   = instr[24:20];
        d.imm   = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        d.itype = ITYPE_U;
        d.rd    = instr[11:7];
        d.imm   = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        d.itype = ITYPE_J;
        d.rd    = instr[11:7];
        d.imm   = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: ;
    endcase
    if (instr[6:0] == OPC_LOAD || instr[6:0] == OPC_STORE) begin
      d.size        = instr[13:12];
      d.is_unsigned = instr[14];
    end
    if (d.itype != ITYPE_NONE) begin
      d.opcode = instr[6:0];
    end
    return d;
  endfunction

endpackage

// File: rtl/decode_fifo.sv
// rtl/decode_fifo.sv - generic synchronous FIFO with flush for decoded records
// Purpose: DEPTH-entry (power of two) in-order buffer; read data is zero when empty.
// Ports:   clk, rst_n (async active-low), i_flush (sync discard),
//          i_wr_valid/o_wr_ready/i_wr_data write side,
//          o_rd_valid/i_rd_ready/o_rd_data read side.
module decode_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_rd_valid,
  input  logic             i_rd_ready,
  output logic [WIDTH-1:0] o_rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                      (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign o_wr_ready = !w_full;
  assign o_rd_valid = !w_empty;
  assign w_push     = i_wr_valid && !w_full && !i_flush;
  assign w_pop      = !w_empty && i_rd_ready && !i_flush;
  // Gating on empty keeps the uninitialised storage from ever reaching the outputs.
  assign o_rd_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage with buffered, in-order output
// Purpose: decodes the instruction at the input and stores the record into a
//          DEPTH-entry decode_fifo; optional illegal-instruction reporting is
//          enabled by defining DECODE_ILLEGAL_EN.
// Ports:   clk, rst_n (async active-low), flush (sync discard);
//          in_valid/in_ready, in_instr, in_pc upstream;
//          out_valid/out_ready, out_opcode/func3/func7, out_rs1/rs2/rd, out_imm,
//          out_itype, out_size, out_unsigned, out_pc, out_illegal downstream;
//          ill_count (16-bit saturating) only with DECODE_ILLEGAL_EN.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_func3,
  output logic [6:0]      out_func7,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_itype,
  output logic [1:0]      out_size,
  output logic            out_unsigned,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
`ifdef DECODE_ILLEGAL_EN
  ,
  output logic [15:0]     ill_count
`endif
);

  import decode_pkg::*;

  localparam int REC_W = 2 * XLEN + 39;

  dec_t             w_dec;
  logic [XLEN-1:0]  w_imm;
  logic             w_illegal;
  logic [REC_W-1:0] w_wr_data;
  logic [REC_W-1:0] w_rd_data;

  assign w_dec = decode(in_instr);
  // Sign-extending cast from the 32-bit immediate to the datapath width.
  assign w_imm = XLEN'($signed(w_dec.imm));

`ifdef DECODE_ILLEGAL_EN
  logic        w_accept;
  logic [15:0] r_ill_count;

  assign w_illegal = (w_dec.itype == ITYPE_NONE) || (in_instr[1:0] != 2'b11);
  // A flushed cycle drops the input transfer, so it is not counted.
  assign w_accept  = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ill_count <= '0;
    end else if (w_accept && w_illegal && (r_ill_count != 16'hFFFF)) begin
      r_ill_count <= r_ill_count + 16'd1;
    end
  end

  assign ill_count = r_ill_count;
`else
  assign w_illegal = 1'b0;
`endif

  assign w_wr_data = {w_illegal, in_pc, w_imm, w_dec.itype, w_dec.size, w_dec.is_unsigned,
                      w_dec.opcode, w_dec.func3, w_dec.func7, w_dec.rs1, w_dec.rs2, w_dec.rd};

  decode_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (flush),
    .i_wr_valid (in_valid),
    .o_wr_ready (in_ready),
    .i_wr_data  (w_wr_data),
    .o_rd_valid (out_valid),
    .i_rd_ready (out_ready),
    .o_rd_data  (w_rd_data)
  );

  assign {out_illegal, out_pc, out_imm, out_itype, out_size, out_unsigned,
          out_opcode, out_func3, out_func7, out_rs1, out_rs2, out_rd} = w_rd_data;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard testbench for decode_stage (XLEN 32 and 64 instances)
`timescale 1ns/1ps
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;

  logic        in_ready, out_valid, out_unsigned, out_illegal;
  logic [6:0]  out_opcode, out_func7;
  logic [2:0]  out_func3, out_itype;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [1:0]  out_size;
  logic [31:0] out_imm, out_pc;

  logic        in_ready_64, out_valid_64, out_unsigned_64, out_illegal_64;
  logic [6:0]  out_opcode_64, out_func7_64;
  logic [2:0]  out_func3_64, out_itype_64;
  logic [4:0]  out_rs1_64, out_rs2_64, out_rd_64;
  logic [1:0]  out_size_64;
  logic [63:0] out_imm_64, out_pc_64;
`ifdef DECODE_ILLEGAL_EN
  logic [15:0] ill_count, ill_count_64;
`endif

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc[31:0]),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_func3(out_func3), .out_func7(out_func7),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_itype(out_itype), .out_size(out_size), .out_unsigned(out_unsigned),
    .out_pc(out_pc), .out_illegal(out_illegal)
`ifdef DECODE_ILLEGAL_EN
    , .ill_count(ill_count)
`endif
  );

  decode_stage #(.XLEN(64), .DEPTH(2)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_64), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid_64), .out_ready(out_ready),
    .out_opcode(out_opcode_64), .out_func3(out_func3_64), .out_func7(out_func7_64),
    .out_rs1(out_rs1_64), .out_rs2(out_rs2_64), .out_rd(out_rd_64), .out_imm(out_imm_64),
    .out_itype(out_itype_64), .out_size(out_size_64), .out_unsigned(out_unsigned_64),
    .out_pc(out_pc_64), .out_illegal(out_illegal_64)
`ifdef DECODE_ILLEGAL_EN
    , .ill_count(ill_count_64)
`endif
  );

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] imm;
    logic [2:0]  it;
    logic [1:0]  sz;
    logic        un;
    logic        ill;
    logic [63:0] pc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   exp_ill = 0;

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [63:0] imm, input logic [2:0] it, input logic [1:0] sz,
                              input logic un, input logic ill);
    exp_t e;
    e.op = op; e.f3 = f3; e.f7 = f7; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    e.imm = imm; e.it = it; e.sz = sz; e.un = un; e.pc = '0;
`ifdef DECODE_ILLEGAL_EN
    e.ill = ill;
`else
    e.ill = 1'b0;
`endif
    return e;
  endfunction

  // Monitor: compares the head of the scoreboard every cycle the DUT presents
  // an entry (so stalled outputs are checked each cycle) and pops on transfer.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out", {159'd0, out_valid}, 160'd0);
      end else begin
        mon_e = sb[0];
        check("fields", {out_opcode, out_func3, out_func7, out_rs1, out_rs2, out_rd,
                         out_itype, out_size, out_unsigned, out_illegal},
                        {mon_e.op, mon_e.f3, mon_e.f7, mon_e.rs1, mon_e.rs2, mon_e.rd,
                         mon_e.it, mon_e.sz, mon_e.un, mon_e.ill});
        check("imm_pc32", {out_imm, out_pc}, {mon_e.imm[31:0], mon_e.pc[31:0]});
        check("imm_pc64", {out_valid_64, out_imm_64, out_pc_64}, {1'b1, mon_e.imm, mon_e.pc});
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  // Holds the input until accepted; the record goes to the scoreboard right after the edge.
  task automatic issue(input logic [31:0] instr, input logic [63:0] pc, input exp_t e);
    int n;
    n = 0;
    in_instr = instr;
    in_pc    = pc;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("accept_timeout", {159'd0, in_ready}, 160'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    e.pc = pc;
    sb.push_back(e);
    if (e.ill) exp_ill++;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 160'(sb.size()), 160'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {159'd0, out_valid}, 160'd0);
    check("rst_fields", {out_imm, out_pc, out_rd, out_itype, out_opcode, out_size}, 160'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", {159'd0, in_ready}, 160'd1);

    // Directed decode vectors, streaming with out_ready high.
    out_ready = 1'b1;
    issue(32'hFFF10093, 64'h1000, mk(7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 2'b10, 1'b0, 1'b0));
    check("latency_valid", {159'd0, out_valid}, 160'd1);
    issue(32'hFE000EE3, 64'h1004, mk(7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 2'b10, 1'b0, 1'b0));
    issue(32'h008000EF, 64'h1008, mk(7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 64'h8, 3'd5, 2'b10, 1'b0, 1'b0));
    issue(32'h123452B7, 64'h100C, mk(7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 64'h12345000, 3'd4, 2'b10, 1'b0, 1'b0));
    issue(32'h00001097, 64'h1010, mk(7'h17, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 64'h1000, 3'd4, 2'b10, 1'b0, 1'b0));
    issue(32'h00415183, 64'h1014, mk(7'h03, 3'd5, 7'h00, 5'd2, 5'd0, 5'd3, 64'h4, 3'd1, 2'b01, 1'b1, 1'b0));
    issue(32'hFFF00203, 64'h1018, mk(7'h03, 3'd0, 7'h00, 5'd0, 5'd0, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 2'b00, 1'b0, 1'b0));
    issue(32'hFE512C23, 64'h101C, mk(7'h23, 3'd2, 7'h00, 5'd2, 5'd5, 5'd0, 64'hFFFF_FFFF_FFFF_FFF8, 3'd2, 2'b10, 1'b0, 1'b0));
    issue(32'h002081B3, 64'h1020, mk(7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 64'h0, 3'd0, 2'b10, 1'b0, 1'b0));
    issue(32'h402081B3, 64'h1024, mk(7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 64'h0, 3'd0, 2'b10, 1'b0, 1'b0));
    issue(32'h0000007F, 64'h1028, mk(7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 64'h0, 3'd7, 2'b10, 1'b0, 1'b1));
    issue(32'h00000010, 64'h102C, mk(7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 64'h0, 3'd7, 2'b10, 1'b0, 1'b1));
    wait_drain();
`ifdef DECODE_ILLEGAL_EN
    check("ill_count", {144'd0, ill_count}, 160'(exp_ill));
`endif

    // Backpressure: two accepts fill the buffer, the third is held until release.
    out_ready = 1'b0;
    issue(32'hFFF10093, 64'h2000, mk(7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 2'b10, 1'b0, 1'b0));
    check("in_ready_one", {159'd0, in_ready}, 160'd1);
    issue(32'h008000EF, 64'h2004, mk(7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 64'h8, 3'd5, 2'b10, 1'b0, 1'b0));
    check("in_ready_full", {159'd0, in_ready}, 160'd0);
    fork
      issue(32'h123452B7, 64'h2008, mk(7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 64'h12345000, 3'd4, 2'b10, 1'b0, 1'b0));
      begin
        repeat (3) @(posedge clk);
        #2;
        check("held_in_ready", {159'd0, in_ready}, 160'd0);
        check("held_sb_size", 160'(sb.size()), 160'd2);
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Flush with one and with two buffered entries plus a concurrent (illegal) input.
    for (int k = 1; k <= 2; k++) begin
      out_ready = 1'b0;
      for (int j = 0; j < k; j++)
        issue(32'h002081B3, 64'h3000 + 64'(j * 4), mk(7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 64'h0, 3'd0, 2'b10, 1'b0, 1'b0));
      in_instr = 32'h0000007F;
      in_pc    = 64'h3FFC;
      in_valid = 1'b1;
      flush    = 1'b1;
      @(posedge clk); #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      sb.delete();
      check("flush_out_valid", {159'd0, out_valid}, 160'd0);
      check("flush_in_ready", {159'd0, in_ready}, 160'd1);
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("flush_stays_empty", {159'd0, out_valid}, 160'd0);
    end
`ifdef DECODE_ILLEGAL_EN
    check("ill_count_flush", {144'd0, ill_count}, 160'(exp_ill));
`endif

    // Asynchronous reset in the middle of a stream.
    out_ready = 1'b0;
    issue(32'hFFF10093, 64'h4000, mk(7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 2'b10, 1'b0, 1'b0));
    issue(32'h0000007F, 64'h4004, mk(7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 64'h0, 3'd7, 2'b10, 1'b0, 1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    exp_ill = 0;
    check("midrst_out_valid", {158'd0, out_valid, out_valid_64}, 160'd0);
    check("midrst_fields", {out_imm, out_pc, out_rd, out_itype, out_opcode, out_illegal}, 160'd0);
`ifdef DECODE_ILLEGAL_EN
    check("midrst_ill_count", {144'd0, ill_count}, 160'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_ready", {158'd0, in_ready, out_valid}, 160'd2);
    out_ready = 1'b1;
    issue(32'h123452B7, 64'h5000, mk(7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 64'h12345000, 3'd4, 2'b10, 1'b0, 1'b0));
    wait_drain();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and immediate width (32 or 64).
REQ-002 SHALL have parameter DEPTH, default 2, output-buffer entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous discard of all buffered entries.
REQ-006 SHALL have port in_valid / in_ready  input / output  1 / 1  upstream handshake.
REQ-007 SHALL have port in_instr / in_pc  input  32 / XLEN  instruction word and its PC.
REQ-008 SHALL have port out_valid / out_ready  output / input  1 / 1  downstream handshake.
REQ-009 SHALL have port out_opcode / out_func3 / out_func7  output  7 / 3 / 7  instruction fields.
REQ-010 SHALL have port out_rs1 / out_rs2 / out_rd  output  5 each  register indices.
REQ-011 SHALL have port out_imm  output  XLEN  sign-extended immediate, byte units.
REQ-012 SHALL have port out_itype  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, NONE=7.
REQ-013 SHALL have port out_size / out_unsigned  output  2 / 1  access size (00 byte, 01 half, 10 word), unsigned load.
REQ-014 SHALL have port out_pc  output  XLEN  PC travelling with the entry.
REQ-015 SHALL have port out_illegal  output  1  unsupported encoding flag.

Function
REQ-016 SHALL decode opcodes OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC combinationally at the input and store the decoded record on acceptance.
REQ-017 SHALL zero every field unused by the format (no X values) and set out_itype=NONE for unsupported opcodes.
REQ-018 SHALL form I/S/B/U/J immediates per RV32I bit layout, B/J with bit0=0 (no right shift), sign-extended from bit 31 to XLEN.
REQ-019 SHALL set out_size from func3[1:0] and out_unsigned from func3[2] for LOAD/STORE; size=10, unsigned=0 otherwise.
REQ-020 SHALL accept on in_valid&&in_ready; in_ready = !full, independent of out_ready.
REQ-021 SHALL present accepted entries in order; out_valid = !empty; latency accept-to-out_valid = 1 cycle when empty.
REQ-022 SHALL pop on out_valid&&out_ready; simultaneous push and pop when neither full nor empty leaves occupancy unchanged.
REQ-023 SHALL hold all out_* stable while out_valid&&!out_ready.
REQ-024 SHALL, on flush, empty the buffer at the next edge and drop any same-cycle input transfer; flush overrides push and pop.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously clear occupancy and pointers: out_valid=0, in_ready=1 after release, all out_* fields 0.
REQ-026 SHALL discard any in-flight entry on reset mid-operation; no partial record emerges after release.

Configuration
REQ-027 SHALL, with DECODE_ILLEGAL_EN defined, set out_illegal=1 for unsupported opcode or in_instr[1:0]!=2'b11, and provide output ill_count (16 bits, saturating at 0xFFFF, incremented once per accepted illegal entry, cleared by reset, not by flush).
REQ-028 SHALL, without DECODE_ILLEGAL_EN, tie out_illegal to 0 and omit ill_count; unsupported opcodes still yield itype NONE.

Structure
REQ-029 SHALL place opcode constants, itype codes, and size codes in shared package decode_pkg.
REQ-030 SHALL implement buffering in sub-module decode_fifo (generic width/DEPTH synchronous FIFO with flush).

Verification
REQ-031 SHALL cover addi x1,x2,-1 (0xFFF10093) -> rd=1, rs1=2, func3=0, itype=1, imm=0xFFFFFFFF, one cycle after accept.
REQ-032 SHALL cover beq x0,x0,-4 (0xFE000EE3) -> itype=3, imm=0xFFFFFFFC, rd=0, func7=0; jal x1,+8 (0x008000EF) -> itype=5, rd=1, imm=0x00000008.
REQ-033 SHALL cover lui x5,0x12345 (0x123452B7) -> itype=4, imm=0x12345000; XLEN=64 build -> imm=0x0000000012345000, and 0xFFF10093 -> imm all ones.
REQ-034 SHALL cover out_ready=0 with 3 pushes, DEPTH=2 -> in_ready=0 after second accept, third held; release -> 3 entries in order, PCs intact.
REQ-035 SHALL cover flush with 2 entries plus concurrent push -> next cycle out_valid=0, no entry emerges; rst_n low mid-stream -> out_valid=0 immediately.
REQ-036 SHALL cover 0x0000007F with DECODE_ILLEGAL_EN -> out_illegal=1, itype=7, ill_count=1; without macro -> out_illegal=0, itype=7.
